// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl: training sequencer for the FIR/LMS equalizer.
//   Generates the symbol-rate strobe, issues the one-shot coefficient
//   force-load, gates LMS adaptation during training and watches the
//   error magnitude to declare convergence or timeout.
// Ports:
//   clkA, reset              clock, asynchronous active-high reset
//   i_start/i_abort          start (retrain) / return to IDLE (abort wins)
//   i_load_req               force-load coefficients before training
//   i_sym_div                clocks per symbol minus 1 (used live)
//   i_train_len/i_err_thr/i_conv_len  training config, latched at start
//   i_error                  signed LMS error, valid with o_sym_en
//   o_sym_en/o_adapt_en/o_coeff_load  strobes and enables to FIR/LMS
//   o_busy/o_converged/o_timeout/o_state/o_sym_cnt  status
module lms_adapt_ctrl #(
  parameter int NBe       = 9,
  parameter int DIV_BITS  = 4,
  parameter int NCNT      = 16,
  parameter int CONV_BITS = 8
) (
  input  logic                  clkA,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_load_req,
  input  logic [DIV_BITS-1:0]   i_sym_div,
  input  logic [NCNT-1:0]       i_train_len,
  input  logic [NBe-2:0]        i_err_thr,
  input  logic [CONV_BITS-1:0]  i_conv_len,
  input  logic signed [NBe-1:0] i_error,
  output logic                  o_sym_en,
  output logic                  o_adapt_en,
  output logic                  o_coeff_load,
  output logic                  o_busy,
  output logic                  o_converged,
  output logic                  o_timeout,
  output logic [2:0]            o_state,
  output logic [NCNT-1:0]       o_sym_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TRAIN = 3'd2,
    ST_TRACK = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [NCNT-1:0]       sym_cnt_q, sym_cnt_d;
  logic [NCNT-1:0]       train_len_q, train_len_d;
  logic [NBe-2:0]        thr_q, thr_d;
  logic [CONV_BITS-1:0]  conv_len_q, conv_len_d;
  logic [CONV_BITS-1:0]  run_q, run_d;
  logic                  conv_q, conv_d;
  logic                  tout_q, tout_d;

  logic                  counting;
  logic                  sym_en;
  logic                  accept;
  logic [NBe-2:0]        err_mag;
  logic [CONV_BITS-1:0]  conv_need;
  logic [CONV_BITS-1:0]  run_next;
  logic [NCNT-1:0]       cnt_next;

  assign counting = state_q inside {ST_TRAIN, ST_TRACK, ST_FAIL};
  // div_q >= i_sym_div (not ==) so a live lowering of the divisor below
  // the current count strobes immediately instead of wrapping the counter.
  assign sym_en   = counting && (div_q >= i_sym_div);
  assign accept   = i_start && !i_abort && (state_q inside {ST_IDLE, ST_TRACK, ST_FAIL});

  // Saturating magnitude: the most negative code maps to the largest
  // positive value; otherwise two's-complement negate on the low bits.
  always_comb begin
    if (!i_error[NBe-1])
      err_mag = i_error[NBe-2:0];
    else if (i_error[NBe-2:0] == '0)
      err_mag = '1;
    else
      err_mag = ~i_error[NBe-2:0] + (NBe-1)'(1);
  end

  assign conv_need = (conv_len_q == '0) ? CONV_BITS'(1) : conv_len_q;
  assign run_next  = (err_mag < thr_q) ? run_q + CONV_BITS'(1) : '0;
  assign cnt_next  = (&sym_cnt_q) ? sym_cnt_q : sym_cnt_q + NCNT'(1);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sym_cnt_d   = sym_cnt_q;
    train_len_d = train_len_q;
    thr_d       = thr_q;
    conv_len_d  = conv_len_q;
    run_d       = run_q;
    conv_d      = conv_q;
    tout_d      = tout_q;

    if (i_abort) begin
      state_d   = ST_IDLE;
      div_d     = '0;
      sym_cnt_d = '0;
      run_d     = '0;
      conv_d    = 1'b0;
      tout_d    = 1'b0;
    end else if (accept) begin
      train_len_d = i_train_len;
      thr_d       = i_err_thr;
      conv_len_d  = i_conv_len;
      div_d       = '0;
      sym_cnt_d   = '0;
      run_d       = '0;
      conv_d      = 1'b0;
      tout_d      = 1'b0;
      state_d     = i_load_req ? ST_LOAD : ST_TRAIN;
    end else begin
      if (counting)
        div_d = sym_en ? '0 : div_q + DIV_BITS'(1);
      case (state_q)
        ST_LOAD: state_d = ST_TRAIN;
        ST_TRAIN: begin
          if (sym_en) begin
            run_d     = run_next;
            sym_cnt_d = cnt_next;
            // Convergence is tested first so it wins over a coincident timeout.
            if (run_next >= conv_need) begin
              state_d = ST_TRACK;
              conv_d  = 1'b1;
            end else if ((train_len_q != '0) && (cnt_next == train_len_q)) begin
              state_d = ST_FAIL;
              tout_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkA or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      sym_cnt_q   <= '0;
      train_len_q <= '0;
      thr_q       <= '0;
      conv_len_q  <= '0;
      run_q       <= '0;
      conv_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sym_cnt_q   <= sym_cnt_d;
      train_len_q <= train_len_d;
      thr_q       <= thr_d;
      conv_len_q  <= conv_len_d;
      run_q       <= run_d;
      conv_q      <= conv_d;
      tout_q      <= tout_d;
    end
  end

  assign o_sym_en     = sym_en;
  assign o_adapt_en   = sym_en && (state_q == ST_TRAIN);
  assign o_coeff_load = (state_q == ST_LOAD);
  assign o_busy       = (state_q == ST_LOAD) || (state_q == ST_TRAIN);
  assign o_converged  = conv_q;
  assign o_timeout    = tout_q;
  assign o_state      = state_q;
  assign o_sym_cnt    = sym_cnt_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
module tb_lms_adapt_ctrl;

  logic        clkA = 1'b0;
  logic        reset;
  logic        i_start, i_abort, i_load_req;
  logic [3:0]  i_sym_div;
  logic [15:0] i_train_len;
  logic [7:0]  i_err_thr;
  logic [7:0]  i_conv_len;
  logic [8:0]  i_error;
  logic        o_sym_en, o_adapt_en, o_coeff_load, o_busy, o_converged, o_timeout;
  logic [2:0]  o_state;
  logic [15:0] o_sym_cnt;

  int checks   = 0;
  int failures = 0;

  lms_adapt_ctrl #(.NBe(9), .DIV_BITS(4), .NCNT(16), .CONV_BITS(8)) dut (
    .clkA(clkA), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_load_req(i_load_req), .i_sym_div(i_sym_div), .i_train_len(i_train_len),
    .i_err_thr(i_err_thr), .i_conv_len(i_conv_len), .i_error(i_error),
    .o_sym_en(o_sym_en), .o_adapt_en(o_adapt_en), .o_coeff_load(o_coeff_load),
    .o_busy(o_busy), .o_converged(o_converged), .o_timeout(o_timeout),
    .o_state(o_state), .o_sym_cnt(o_sym_cnt)
  );

  always #5 clkA = ~clkA;

  // Behavioural reference: states as plain integers 0..4, counters as ints.
  int m_state, m_div, m_cnt, m_run, m_tlen, m_thr, m_clen;
  bit m_conv, m_tout;

  function automatic void model_reset();
    m_state = 0; m_div = 0; m_cnt = 0; m_run = 0;
    m_tlen = 0; m_thr = 0; m_clen = 0; m_conv = 0; m_tout = 0;
  endfunction

  function automatic bit exp_sym_en();
    return (m_state >= 2) && (m_div >= int'(i_sym_div));
  endfunction

  function automatic logic [25:0] exp_vec();
    bit se;
    se = exp_sym_en();
    return {3'(m_state), se, se && (m_state == 2), m_state == 1,
            m_state == 1 || m_state == 2, m_conv, m_tout, 16'(m_cnt)};
  endfunction

  function automatic void model_step();
    bit se;
    int e, mag, need;
    se = exp_sym_en();
    if (i_abort) begin
      m_state = 0; m_div = 0; m_cnt = 0; m_run = 0; m_conv = 0; m_tout = 0;
    end else if (i_start && (m_state == 0 || m_state == 3 || m_state == 4)) begin
      m_tlen = int'(i_train_len); m_thr = int'(i_err_thr); m_clen = int'(i_conv_len);
      m_div = 0; m_cnt = 0; m_run = 0; m_conv = 0; m_tout = 0;
      m_state = i_load_req ? 1 : 2;
    end else begin
      if (m_state >= 2) m_div = se ? 0 : m_div + 1;
      if (m_state == 1) m_state = 2;
      else if (m_state == 2 && se) begin
        e   = int'($signed(i_error));
        mag = (e < 0) ? -e : e;
        if (mag > 255) mag = 255;
        m_run = (mag < m_thr) ? m_run + 1 : 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        need = (m_clen == 0) ? 1 : m_clen;
        if (m_run >= need) begin
          m_state = 3; m_conv = 1;
        end else if (m_tlen != 0 && m_cnt == m_tlen) begin
          m_state = 4; m_tout = 1;
        end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clkA);
    #1;
  endtask

  task automatic start_train(input bit load, input int div, input int tl,
                             input int thr, input int cl);
    i_abort = 1'b1;
    #1;
    tick();
    i_abort = 1'b0;
    i_load_req = load; i_sym_div = 4'(div); i_train_len = 16'(tl);
    i_err_thr = 8'(thr); i_conv_len = 8'(cl); i_start = 1'b1;
    #1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    i_start = 0; i_abort = 0; i_load_req = 0; i_sym_div = 0;
    i_train_len = 0; i_err_thr = 0; i_conv_len = 0; i_error = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clkA);
    #1;
    obs = {o_state, o_sym_en, o_adapt_en, o_coeff_load, o_busy, o_converged, o_timeout, o_sym_cnt};
    checks++;
    if (obs !== 26'd0) begin
      failures++; $display("FAIL reset_init: got %h expected 0", obs);
    end
    reset = 1'b0;
    start_train(0, 0, 0, 0, 1);
    repeat (3) tick();
    checks++;
    if (o_state !== 3'd2 || o_sym_cnt !== 16'd3) begin
      failures++; $display("FAIL reset_pre_train: state %0d cnt %0d expected 2/3", o_state, o_sym_cnt);
    end
    #2 reset = 1'b1;
    #1;
    obs = {o_state, o_sym_en, o_adapt_en, o_coeff_load, o_busy, o_converged, o_timeout, o_sym_cnt};
    checks++;
    if (obs !== 26'd0) begin
      failures++; $display("FAIL reset_async: got %h expected 0", obs);
    end
    model_reset();
    @(posedge clkA);
    #1 reset = 1'b0;
  endtask

  task automatic test_start_load();
    bit ex;
    start_train(1, 3, 0, 0, 1);
    checks++;
    if (o_coeff_load !== 1'b1 || o_state !== 3'd1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL load_pulse: load %0b state %0d expected 1/1", o_coeff_load, o_state);
    end
    #1;
    tick();
    checks++;
    if (o_coeff_load !== 1'b0 || o_state !== 3'd2) begin
      failures++; $display("FAIL load_to_train: load %0b state %0d expected 0/2", o_coeff_load, o_state);
    end
    for (int t = 0; t < 12; t++) begin
      #1;
      ex = (t % 4 == 3);
      checks++;
      if (o_sym_en !== ex || o_adapt_en !== ex) begin
        failures++; $display("FAIL load_strobe t=%0d: sym %0b adapt %0b expected %0b", t, o_sym_en, o_adapt_en, ex);
      end
      tick();
    end
    checks++;
    if (o_sym_cnt !== 16'd3) begin
      failures++; $display("FAIL load_symcnt: got %0d expected 3", o_sym_cnt);
    end
  endtask

  task automatic test_convergence();
    int errs[7] = '{10, 5, -7, 8, 3, 2, -1};
    int k = 0;
    int t = 0;
    bit ex;
    start_train(0, 1, 0, 8, 3);
    while (k < 7 && t < 100) begin
      i_error = 9'(errs[k]);
      #1;
      ex = (t % 2 == 1);
      checks++;
      if (o_sym_en !== ex || o_adapt_en !== ex || o_state !== 3'd2) begin
        failures++; $display("FAIL conv_train t=%0d: sym %0b adapt %0b state %0d expected %0b/%0b/2", t, o_sym_en, o_adapt_en, o_state, ex, ex);
      end
      tick();
      if (ex) k++;
      t++;
    end
    checks++;
    if (k != 7) begin
      failures++; $display("FAIL conv_budget: strobes %0d expected 7", k);
    end
    checks++;
    if (o_state !== 3'd3 || o_converged !== 1'b1 || o_timeout !== 1'b0 || o_sym_cnt !== 16'd7) begin
      failures++; $display("FAIL conv_done: state %0d conv %0b tout %0b cnt %0d expected 3/1/0/7", o_state, o_converged, o_timeout, o_sym_cnt);
    end
    for (int j = 0; j < 6; j++) begin
      #1;
      ex = (t % 2 == 1);
      checks++;
      if (o_sym_en !== ex || o_adapt_en !== 1'b0 || o_sym_cnt !== 16'd7) begin
        failures++; $display("FAIL conv_track: sym %0b adapt %0b cnt %0d expected %0b/0/7", o_sym_en, o_adapt_en, o_sym_cnt, ex);
      end
      tick();
      t++;
    end
  endtask

  task automatic test_timeout();
    start_train(0, 0, 5, 255, 1);
    i_error = 9'h100;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (o_sym_en !== 1'b1 || o_adapt_en !== 1'b1) begin
        failures++; $display("FAIL tout_strobe: sym %0b adapt %0b expected 1/1", o_sym_en, o_adapt_en);
      end
      tick();
    end
    checks++;
    if (o_state !== 3'd2 || o_timeout !== 1'b0) begin
      failures++; $display("FAIL tout_early: state %0d tout %0b expected 2/0", o_state, o_timeout);
    end
    #1;
    tick();
    checks++;
    if (o_state !== 3'd4 || o_timeout !== 1'b1 || o_converged !== 1'b0 || o_sym_cnt !== 16'd5) begin
      failures++; $display("FAIL tout_fail: state %0d tout %0b conv %0b cnt %0d expected 4/1/0/5", o_state, o_timeout, o_converged, o_sym_cnt);
    end
    repeat (2) tick();
    checks++;
    if (o_sym_en !== 1'b1 || o_adapt_en !== 1'b0 || o_sym_cnt !== 16'd5 || o_busy !== 1'b0) begin
      failures++; $display("FAIL tout_hold: sym %0b adapt %0b cnt %0d busy %0b expected 1/0/5/0", o_sym_en, o_adapt_en, o_sym_cnt, o_busy);
    end
  endtask

  task automatic test_simultaneous();
    start_train(0, 0, 3, 8, 3);
    i_error = 9'd1;
    repeat (3) tick();
    checks++;
    if (o_state !== 3'd3 || o_converged !== 1'b1 || o_timeout !== 1'b0) begin
      failures++; $display("FAIL simul_conv_wins: state %0d conv %0b tout %0b expected 3/1/0", o_state, o_converged, o_timeout);
    end
    i_start = 1'b1; i_abort = 1'b1;
    #1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    #1;
    checks++;
    if ({o_state, o_converged, o_timeout, o_sym_cnt, o_busy, o_sym_en} !== 22'd0) begin
      failures++; $display("FAIL simul_abort: state %0d conv %0b tout %0b cnt %0d sym %0b expected all 0", o_state, o_converged, o_timeout, o_sym_cnt, o_sym_en);
    end
    tick();
  endtask

  task automatic test_divider();
    bit ex;
    start_train(0, 0, 0, 0, 1);
    for (int j = 0; j < 6; j++) begin
      #1;
      checks++;
      if (o_sym_en !== 1'b1) begin
        failures++; $display("FAIL div0: sym %0b expected 1", o_sym_en);
      end
      tick();
    end
    start_train(0, 7, 0, 0, 1);
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++;
      if (o_sym_en !== 1'b0) begin
        failures++; $display("FAIL div7_idle: sym %0b expected 0", o_sym_en);
      end
      tick();
    end
    i_sym_div = 4'd2;
    for (int j = 0; j < 7; j++) begin
      #1;
      ex = (j % 3 == 0);
      checks++;
      if (o_sym_en !== ex) begin
        failures++; $display("FAIL div_lower j=%0d: sym %0b expected %0b", j, o_sym_en, ex);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [25:0] obs, ex;
    for (int c = 0; c < 1500; c++) begin
      i_start     = ($urandom_range(0, 39) == 0);
      i_abort     = ($urandom_range(0, 199) == 0);
      i_load_req  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) i_sym_div = 4'($urandom_range(0, 3));
      i_train_len = 16'($urandom_range(0, 30));
      i_err_thr   = 8'($urandom_range(0, 60));
      i_conv_len  = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) i_error = 9'($urandom);
      else i_error = 9'(int'($urandom_range(0, 80)) - 40);
      #1;
      obs = {o_state, o_sym_en, o_adapt_en, o_coeff_load, o_busy, o_converged, o_timeout, o_sym_cnt};
      ex  = exp_vec();
      checks++;
      if (obs !== ex) begin
        failures++; $display("FAIL random c=%0d: got %h expected %h", c, obs, ex);
      end
      tick();
    end
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_load();
    test_convergence();
    test_timeout();
    test_simultaneous();
    test_divider();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
